// File: rtl/vic_irq_ctrl.sv
// Vectored interrupt controller.
// Synchronizes raw interrupt lines, detects edges or levels per channel,
// keeps a pending vector, and presents the most urgent pending channel
// to the CPU through an IDLE -> REQ -> SERVICE handshake with no nesting.
module vic_irq_ctrl #(
    parameter int N_IRQ  = 31,
    parameter int PRIO_W = 2,
    localparam int AW    = $clog2(N_IRQ)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [N_IRQ-1:0]        i_ext,
    input  logic [4*N_IRQ-1:0]      i_cfg,
    input  logic [PRIO_W*N_IRQ-1:0] i_prio,
    input  logic                    i_en,
    input  logic                    i_ack,
    input  logic                    i_eoi,
    output logic                    o_irq,
    output logic [AW-1:0]           o_irq_addr,
    output logic [PRIO_W-1:0]       o_irq_prio,
    output logic [N_IRQ-1:0]        o_pending
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } state_t;

    state_t             state;
    logic [N_IRQ-1:0]   sync1;
    logic [N_IRQ-1:0]   sync2;
    logic [N_IRQ-1:0]   hist;
    logic [N_IRQ-1:0]   pending;
    logic [N_IRQ-1:0]   pending_nxt;
    logic [1:0]         arm_cnt;
    logic               armed;
    logic               ack_fire;
    logic               any_pending;
    logic [AW-1:0]      arb_addr;
    logic [PRIO_W-1:0]  arb_prio;
    logic               arb_found;

    // Two-stage synchronizer followed by a history stage for edge detection.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1 <= '0;
            sync2 <= '0;
            hist  <= '0;
        end else begin
            sync1 <= i_ext;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    // Arming counter: edges are ignored until the synchronizer and history
    // stages have been refilled from the live lines after reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            arm_cnt <= 2'd0;
        end else if (arm_cnt != 2'd3) begin
            arm_cnt <= arm_cnt + 2'd1;
        end
    end

    assign armed       = (arm_cnt == 2'd3);
    assign ack_fire    = (state == REQ) && i_ack;
    assign any_pending = |pending;

    // Next pending vector: level channels follow the line, edge channels set on
    // a detected edge and clear on acknowledge of that channel (set wins).
    // NOTE: pending_nxt gets a full default before any conditional update so the
    // block stays purely combinational with no inferred latch.
    always_comb begin
        pending_nxt = pending;
        for (int c = 0; c < N_IRQ; c++) begin
            if (!i_cfg[4*c+3]) begin
                pending_nxt[c] = 1'b0;
            end else if (!i_cfg[4*c+2] && !i_cfg[4*c+1]) begin
                pending_nxt[c] = (sync2[c] == i_cfg[4*c]);
            end else begin
                if (ack_fire && (o_irq_addr == AW'(c))) begin
                    pending_nxt[c] = 1'b0;
                end
                if (armed && ((i_cfg[4*c+2] && sync2[c] && !hist[c]) ||
                              (i_cfg[4*c+1] && !sync2[c] && hist[c]))) begin
                    pending_nxt[c] = 1'b1;
                end
            end
        end
    end

    // Pending register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    assign o_pending = pending;

    // Arbiter: highest priority among pending channels, lowest index on a tie
    // (strict greater-than keeps the earlier, lower-index winner).
    always_comb begin
        arb_found = 1'b0;
        arb_addr  = '0;
        arb_prio  = '0;
        for (int c = 0; c < N_IRQ; c++) begin
            if (pending[c] &&
                (!arb_found || (i_prio[c*PRIO_W +: PRIO_W] > arb_prio))) begin
                arb_found = 1'b1;
                arb_addr  = AW'(c);
                arb_prio  = i_prio[c*PRIO_W +: PRIO_W];
            end
        end
    end

    // Request handshake FSM with registered outputs; the presented channel is
    // refreshed every cycle in REQ and frozen once acknowledged.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            o_irq      <= 1'b0;
            o_irq_addr <= '0;
            o_irq_prio <= '0;
        end else begin
            case (state)
                IDLE: begin
                    o_irq <= 1'b0;
                    if (i_en && any_pending) begin
                        state      <= REQ;
                        o_irq      <= 1'b1;
                        o_irq_addr <= arb_addr;
                        o_irq_prio <= arb_prio;
                    end
                end
                REQ: begin
                    if (i_ack) begin
                        state <= SERVICE;
                        o_irq <= 1'b0;
                    end else if (!i_en || !any_pending) begin
                        state <= IDLE;
                        o_irq <= 1'b0;
                    end else begin
                        o_irq_addr <= arb_addr;
                        o_irq_prio <= arb_prio;
                    end
                end
                SERVICE: begin
                    o_irq <= 1'b0;
                    if (i_eoi) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    o_irq <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vic_irq_ctrl.sv
// Directed bench for vic_irq_ctrl. Expected presentations (addr, prio) are
// queued by the stimulus; a monitor pops one each time the DUT raises o_irq
// or changes the presented channel. Timing-specific points are checked inline.
module tb_vic_irq_ctrl;

    localparam int N_IRQ  = 31;
    localparam int PRIO_W = 2;
    localparam int AW     = $clog2(N_IRQ);

    typedef struct {
        logic [AW-1:0]     addr;
        logic [PRIO_W-1:0] prio;
    } exp_t;

    logic                    i_clk = 1'b0;
    logic                    i_rst;
    logic [N_IRQ-1:0]        i_ext;
    logic [4*N_IRQ-1:0]      i_cfg;
    logic [PRIO_W*N_IRQ-1:0] i_prio;
    logic                    i_en;
    logic                    i_ack;
    logic                    i_eoi;
    logic                    o_irq;
    logic [AW-1:0]           o_irq_addr;
    logic [PRIO_W-1:0]       o_irq_prio;
    logic [N_IRQ-1:0]        o_pending;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    vic_irq_ctrl #(.N_IRQ(N_IRQ), .PRIO_W(PRIO_W)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_ext      (i_ext),
        .i_cfg      (i_cfg),
        .i_prio     (i_prio),
        .i_en       (i_en),
        .i_ack      (i_ack),
        .i_eoi      (i_eoi),
        .o_irq      (o_irq),
        .o_irq_addr (o_irq_addr),
        .o_irq_prio (o_irq_prio),
        .o_pending  (o_pending)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic set_cfg(input int ch, input logic [3:0] v);
        i_cfg[4*ch +: 4] = v;
    endtask

    task automatic set_prio(input int ch, input logic [PRIO_W-1:0] p);
        i_prio[PRIO_W*ch +: PRIO_W] = p;
    endtask

    task automatic expect_present(input int ch, input logic [PRIO_W-1:0] p);
        exp_t e;
        e.addr = AW'(ch);
        e.prio = p;
        sb.push_back(e);
    endtask

    task automatic pulse_ack();
        i_ack = 1'b1;
        tick(1);
        i_ack = 1'b0;
    endtask

    task automatic pulse_eoi();
        i_eoi = 1'b1;
        tick(1);
        i_eoi = 1'b0;
    endtask

    // Monitor: a presentation is o_irq rising or the presented address changing.
    initial begin
        logic          prev_irq;
        logic [AW-1:0] prev_addr;
        exp_t          e;
        prev_irq  = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                prev_irq = 1'b0;
            end else begin
                if (o_irq && (!prev_irq || (o_irq_addr != prev_addr))) begin
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_present: got addr %0d prio %0d, none expected at %0t",
                                 o_irq_addr, o_irq_prio, $time);
                    end else begin
                        e = sb.pop_front();
                        check("present_addr", 64'(o_irq_addr), 64'(e.addr));
                        check("present_prio", 64'(o_irq_prio), 64'(e.prio));
                    end
                end
                prev_irq  = o_irq;
                prev_addr = o_irq_addr;
            end
        end
    end

    initial begin
        i_rst  = 1'b1;
        i_ext  = '0;
        i_cfg  = '0;
        i_prio = '0;
        i_en   = 1'b1;
        i_ack  = 1'b0;
        i_eoi  = 1'b0;

        // Reset with ch6 (rising edge) line already high.
        set_cfg(6, 4'b1100);
        set_prio(6, 2'd1);
        i_ext[6] = 1'b1;
        tick(3);
        check("rst_irq", 64'(o_irq), 64'd0);
        check("rst_addr", 64'(o_irq_addr), 64'd0);
        check("rst_prio", 64'(o_irq_prio), 64'd0);
        check("rst_pending", 64'(o_pending), 64'd0);
        i_rst = 1'b0;
        tick(8);
        check("arm_no_pend", 64'(o_pending), 64'd0);
        check("arm_no_irq", 64'(o_irq), 64'd0);
        i_ext[6] = 1'b0;
        tick(4);
        expect_present(6, 2'd1);
        i_ext[6] = 1'b1;
        tick(3);
        check("ch6_pend", 64'(o_pending[6]), 64'd1);
        tick(1);
        check("ch6_irq", 64'(o_irq), 64'd1);
        pulse_ack();
        check("ch6_ack_irq", 64'(o_irq), 64'd0);
        check("ch6_ack_pend", 64'(o_pending), 64'd0);
        pulse_eoi();
        set_cfg(6, 4'b0000);
        i_ext[6] = 1'b0;
        tick(4);

        // ch5 rising edge: pend after 3 clocks, present after 4.
        set_cfg(5, 4'b1100);
        set_prio(5, 2'd2);
        expect_present(5, 2'd2);
        i_ext[5] = 1'b1;
        tick(2);
        check("ch5_pend_early", 64'(o_pending[5]), 64'd0);
        tick(1);
        check("ch5_pend", 64'(o_pending[5]), 64'd1);
        check("ch5_irq_early", 64'(o_irq), 64'd0);
        tick(1);
        check("ch5_irq", 64'(o_irq), 64'd1);
        check("ch5_addr", 64'(o_irq_addr), 64'd5);
        pulse_ack();
        check("ch5_ack_irq", 64'(o_irq), 64'd0);
        check("ch5_ack_pend", 64'(o_pending[5]), 64'd0);
        tick(2);
        check("ch5_service_irq", 64'(o_irq), 64'd0);
        pulse_eoi();
        tick(2);
        check("ch5_idle_irq", 64'(o_irq), 64'd0);
        set_cfg(5, 4'b0000);
        i_ext[5] = 1'b0;
        tick(4);

        // ch3 prio 1 and ch9 prio 3 pend together: ch9 first, then ch3.
        set_cfg(3, 4'b1100);
        set_prio(3, 2'd1);
        set_cfg(9, 4'b1100);
        set_prio(9, 2'd3);
        expect_present(9, 2'd3);
        i_ext[3] = 1'b1;
        i_ext[9] = 1'b1;
        tick(3);
        check("c39_pend", 64'(o_pending), 64'h208);
        tick(1);
        check("c39_addr9", 64'(o_irq_addr), 64'd9);
        pulse_ack();
        check("c39_pend_after_ack", 64'(o_pending), 64'h8);
        set_cfg(9, 4'b0000);
        tick(1);
        check("c39_addr_frozen", 64'(o_irq_addr), 64'd9);
        expect_present(3, 2'd1);
        pulse_eoi();
        check("c39_idle_irq", 64'(o_irq), 64'd0);
        tick(1);
        check("c39_irq3", 64'(o_irq), 64'd1);
        check("c39_addr3", 64'(o_irq_addr), 64'd3);
        pulse_ack();
        pulse_eoi();
        set_cfg(3, 4'b0000);
        i_ext[3] = 1'b0;
        i_ext[9] = 1'b0;
        tick(4);

        // ch2 and ch7 equal priority: lower index first.
        set_cfg(2, 4'b1100);
        set_prio(2, 2'd2);
        set_cfg(7, 4'b1100);
        set_prio(7, 2'd2);
        expect_present(2, 2'd2);
        i_ext[2] = 1'b1;
        i_ext[7] = 1'b1;
        tick(4);
        check("tie_addr2", 64'(o_irq_addr), 64'd2);
        pulse_ack();
        expect_present(7, 2'd2);
        pulse_eoi();
        tick(1);
        check("tie_addr7", 64'(o_irq_addr), 64'd7);
        pulse_ack();
        pulse_eoi();
        set_cfg(2, 4'b0000);
        set_cfg(7, 4'b0000);
        i_ext[2] = 1'b0;
        i_ext[7] = 1'b0;
        tick(4);

        // ch4 level-high held through EOI, then dropped while requesting.
        set_cfg(4, 4'b1001);
        set_prio(4, 2'd1);
        expect_present(4, 2'd1);
        i_ext[4] = 1'b1;
        tick(3);
        check("lvl_pend", 64'(o_pending[4]), 64'd1);
        tick(1);
        check("lvl_addr", 64'(o_irq_addr), 64'd4);
        pulse_ack();
        check("lvl_ack_irq", 64'(o_irq), 64'd0);
        check("lvl_ack_pend", 64'(o_pending[4]), 64'd1);
        tick(2);
        expect_present(4, 2'd1);
        pulse_eoi();
        check("lvl_eoi_idle", 64'(o_irq), 64'd0);
        tick(1);
        check("lvl_reassert", 64'(o_irq), 64'd1);
        i_ext[4] = 1'b0;
        tick(3);
        check("lvl_drop_pend", 64'(o_pending[4]), 64'd0);
        check("lvl_drop_irq_hold", 64'(o_irq), 64'd1);
        tick(1);
        check("lvl_drop_irq", 64'(o_irq), 64'd0);
        set_cfg(4, 4'b0000);
        tick(2);

        // ch1 re-edges during SERVICE, then reset mid-SERVICE.
        set_cfg(1, 4'b1100);
        set_prio(1, 2'd2);
        expect_present(1, 2'd2);
        i_ext[1] = 1'b1;
        tick(4);
        check("c1_addr", 64'(o_irq_addr), 64'd1);
        pulse_ack();
        i_ext[1] = 1'b0;
        tick(3);
        i_ext[1] = 1'b1;
        tick(3);
        check("c1_repend", 64'(o_pending[1]), 64'd1);
        check("c1_no_nest", 64'(o_irq), 64'd0);
        tick(3);
        check("c1_no_nest_late", 64'(o_irq), 64'd0);
        expect_present(1, 2'd2);
        pulse_eoi();
        tick(1);
        check("c1_after_eoi", 64'(o_irq), 64'd1);
        pulse_ack();
        check("c1_svc_addr", 64'(o_irq_addr), 64'd1);
        i_rst = 1'b1;
        #2;
        check("midrst_irq", 64'(o_irq), 64'd0);
        check("midrst_addr", 64'(o_irq_addr), 64'd0);
        check("midrst_prio", 64'(o_irq_prio), 64'd0);
        check("midrst_pend", 64'(o_pending), 64'd0);
        tick(1);
        i_rst = 1'b0;
        tick(6);
        check("postrst_pend", 64'(o_pending), 64'd0);
        check("postrst_irq", 64'(o_irq), 64'd0);
        set_cfg(1, 4'b0000);
        i_ext[1] = 1'b0;
        tick(4);

        // Preemption in REQ, then global disable in REQ.
        set_cfg(2, 4'b1100);
        set_prio(2, 2'd0);
        set_cfg(8, 4'b1100);
        set_prio(8, 2'd3);
        expect_present(2, 2'd0);
        i_ext[2] = 1'b1;
        tick(4);
        check("pre_addr2", 64'(o_irq_addr), 64'd2);
        check("pre_prio0", 64'(o_irq_prio), 64'd0);
        expect_present(8, 2'd3);
        i_ext[8] = 1'b1;
        tick(3);
        check("pre_pend8", 64'(o_pending[8]), 64'd1);
        check("pre_still2", 64'(o_irq_addr), 64'd2);
        tick(1);
        check("pre_addr8", 64'(o_irq_addr), 64'd8);
        check("pre_prio3", 64'(o_irq_prio), 64'd3);
        i_en = 1'b0;
        tick(1);
        check("dis_irq", 64'(o_irq), 64'd0);
        expect_present(8, 2'd3);
        i_en = 1'b1;
        tick(1);
        check("reen_addr8", 64'(o_irq_addr), 64'd8);
        pulse_ack();
        expect_present(2, 2'd0);
        pulse_eoi();
        tick(1);
        check("last_addr2", 64'(o_irq_addr), 64'd2);
        pulse_ack();
        pulse_eoi();
        tick(3);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vic_irq_ctrl.md
VIC_IRQ_CTRL -- requirements
Module: vic_irq_ctrl

Interface
REQ-001 Parameter N_IRQ, default 31: number of interrupt channels, legal range 2..64.
REQ-002 Parameter PRIO_W, default 2: width of each channel priority field.
REQ-003 Localparam AW = $clog2(N_IRQ): width of the channel index.
REQ-004 i_clk  in  1  single clock; all state changes on its rising edge.
REQ-005 i_rst  in  1  reset, asynchronous, active-high.
REQ-006 i_ext  in  N_IRQ  raw, asynchronous interrupt source lines.
REQ-007 i_cfg  in  4*N_IRQ  per channel c, bits [4c+3:4c]: {en, rise, fall, lvl}.
REQ-008 i_prio  in  PRIO_W*N_IRQ  per channel priority; a larger value is more urgent.
REQ-009 i_en  in  1  global request enable.
REQ-010 i_ack  in  1  one-cycle CPU acknowledge of the presented request.
REQ-011 i_eoi  in  1  one-cycle end-of-interrupt from the CPU.
REQ-012 o_irq  out  1  request to the CPU, level, registered.
REQ-013 o_irq_addr  out  AW  index of the presented or in-service channel, registered.
REQ-014 o_irq_prio  out  PRIO_W  priority of o_irq_addr, registered.
REQ-015 o_pending  out  N_IRQ  pending vector, registered.

Function
REQ-016 Each i_ext bit shall pass through a 2-flop synchronizer, then a history flop used for edge detection.
REQ-017 Rising-edge channel (en=1, rise=1): pending[c] sets on the cycle the history flop shows a sync 0->1 transition.
REQ-018 Falling-edge channel (en=1, fall=1): pending[c] sets on a sync 1->0 transition. rise=fall=1 sets on both edges.
REQ-019 Level channel (en=1, rise=fall=0): pending[c] equals (sync[c]==lvl), updated every cycle.
REQ-020 Edge latency: pending is visible 3 clocks after i_ext changes (2 sync stages plus the pending register).
REQ-021 en=0 on a channel shall clear its pending bit on the next clock and block any new set.
REQ-022 An edge-channel pending bit shall clear only on i_ack for that channel. Set and clear in the same cycle: set wins.
REQ-023 Arbitration (combinational over pending): select the highest i_prio among pending channels; on a tie, select the lowest index.
REQ-024 FSM states: IDLE, REQ, SERVICE.
REQ-025 IDLE -> REQ when i_en=1 and any pending bit is set. On that clock, register o_irq=1, o_irq_addr and o_irq_prio from the arbiter.
REQ-026 In REQ, addr and prio shall be re-registered every cycle, so a higher-priority arrival preempts the presented channel before acknowledge.
REQ-027 REQ -> SERVICE on i_ack: o_irq=0 on the next clock, o_irq_addr frozen, edge pending of that channel cleared.
REQ-028 REQ -> IDLE with o_irq=0 when i_en=0 or pending becomes all-zero.
REQ-029 SERVICE -> IDLE on i_eoi; no new request may be presented while in SERVICE (no nesting).
REQ-030 A level channel still asserted at i_eoi shall be presented again via IDLE -> REQ, at the earliest 1 clock after returning to IDLE.
REQ-031 An edge on the in-service channel during SERVICE shall re-set its pending bit; it is serviced after i_eoi.
REQ-032 i_ack outside REQ and i_eoi outside SERVICE shall be ignored.
REQ-033 Configuration changes in SERVICE shall not alter o_irq_addr.

Reset
REQ-034 While i_rst=1: state IDLE, o_irq=0, o_irq_addr=0, o_irq_prio=0, o_pending=0, synchronizer and history flops 0.
REQ-035 Edge detection shall be disarmed for the first 3 clocks after i_rst deasserts (3-count arming counter), so lines already high at reset do not create edges.
REQ-036 Level channels shall not be disarmed; they pend from clock 3 after reset release.
REQ-037 Reset asserted mid-REQ or mid-SERVICE shall drop o_irq immediately (asynchronously) and discard all pending state.

Verification
REQ-038 N_IRQ=31. ch5 rising-edge, i_en=1; i_ext[5] 0->1 -> o_pending[5]=1 after 3 clocks, o_irq=1 with addr=5 after 4 clocks; i_ack -> o_irq=0, pending[5]=0; i_eoi -> IDLE.
REQ-039 ch3 prio 1 and ch9 prio 3 edges pend in the same cycle -> addr=9. After i_ack and i_eoi -> addr=3. ch2 and ch7 both prio 2 -> addr=2.
REQ-040 ch4 level-high held at 1 through i_eoi -> o_irq reasserts with addr=4 1 clock after IDLE. Line drops before i_ack -> o_irq=0, state IDLE.
REQ-041 i_ext[6]=1 during reset, ch6 rising-edge -> no pending after release. A later 0->1 pends normally.
REQ-042 ch1 in SERVICE receives a new rising edge -> pending[1]=1 and o_irq stays 0 until i_eoi, then addr=1. Reset pulse mid-SERVICE -> all outputs 0.
REQ-043 In REQ with addr=2 (prio 0), ch8 prio 3 pends -> addr changes to 8 next clock. i_en=0 in REQ -> o_irq=0 next clock.
